// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the future fetch unit.
package imem_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned BYTE_IDX_W  = $clog2(INSTR_BYTES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    WRITE  = 3'd2,
    VERIFY = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } ldr_state_e;

  // States in which a start pulse arms a new load.
  function automatic logic start_allowed(input ldr_state_e s);
    return (s == IDLE) || (s == DONE) || (s == ERROR);
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Packs accepted stream bytes little-endian into one instruction word.
module imem_byte_packer
  import imem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            data,
  input  logic                  last,
  output logic [BYTE_IDX_W-1:0] byte_idx,
  output logic [31:0]           word_c,
  output logic                  word_end_c
);

  logic [7:0] lane0;
  logic [7:0] lane1;
  logic [7:0] lane2;

  // Current byte completes the word when it fills the top lane or ends the image.
  assign word_end_c = last || (byte_idx == BYTE_IDX_W'(INSTR_BYTES - 1));

  // Word as it would be written if the current byte ends it; lanes above are zero.
  always_comb begin
    word_c = '0;
    case (byte_idx)
      2'd0:    word_c = {24'h0, data};
      2'd1:    word_c = {16'h0, data, lane0};
      2'd2:    word_c = {8'h0, data, lane1, lane0};
      default: word_c = {data, lane2, lane1, lane0};
    endcase
  end

  // Lane capture and byte index, wrapping after the last lane or on s_last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_idx <= '0;
      lane0    <= '0;
      lane1    <= '0;
      lane2    <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (accept) begin
      case (byte_idx)
        2'd0:    lane0 <= data;
        2'd1:    lane1 <= data;
        2'd2:    lane2 <= data;
        default: ;
      endcase
      if (word_end_c) byte_idx <= '0;
      else            byte_idx <= byte_idx + BYTE_IDX_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory programmer: loads a byte stream, verifies by read-back sum,
// then releases the core from reset.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DIR_WIDTH  = 10,
  parameter int unsigned MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [7:0]            s_data,
  input  logic                  s_last,
  output logic [DIR_WIDTH-1:0]  dir,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] rd,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DIR_WIDTH-2:0]  word_count,
  output logic                  cpu_rst_n
);

  localparam int unsigned WC_W = DIR_WIDTH - 1;

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("imem_loader: DATA_WIDTH must be 32");
  end

  ldr_state_e            state;
  logic [31:0]           sum;
  logic [31:0]           vsum;
  logic [WC_W-1:0]       vk;
  logic                  phase;
  logic                  last_seen;

  logic                  accept_c;
  logic                  start_take_c;
  logic [BYTE_IDX_W-1:0] byte_idx;
  logic [31:0]           word_c;
  logic                  word_end_c;
  logic [31:0]           vsum_next_c;
  logic                  verify_ok_c;

  assign accept_c     = s_valid && s_ready && (state == FILL);
  assign start_take_c = start && start_allowed(state);
  assign vsum_next_c  = vsum + rd;
  assign verify_ok_c  = (vsum_next_c == sum);

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_take_c),
    .accept     (accept_c),
    .data       (s_data),
    .last       (s_last),
    .byte_idx   (byte_idx),
    .word_c     (word_c),
    .word_end_c (word_end_c)
  );

  // Loader FSM with registered outputs, address counters and checksums.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      s_ready    <= 1'b0;
      we         <= 1'b0;
      dir        <= '0;
      data_in    <= '0;
      a          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      cpu_rst_n  <= 1'b0;
      sum        <= '0;
      vsum       <= '0;
      vk         <= '0;
      phase      <= 1'b0;
      last_seen  <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start_take_c) begin
            state      <= FILL;
            s_ready    <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_rst_n  <= 1'b0;
            word_count <= '0;
            sum        <= '0;
            last_seen  <= 1'b0;
          end
        end

        FILL: begin
          if (accept_c) begin
            if (word_count == WC_W'(MAX_WORDS)) begin
              state   <= ERROR;
              s_ready <= 1'b0;
              busy    <= 1'b0;
              error   <= 1'b1;
            end else if (word_end_c) begin
              state     <= WRITE;
              s_ready   <= 1'b0;
              we        <= 1'b1;
              dir       <= {word_count[WC_W-2:0], 2'b00};
              data_in   <= word_c;
              last_seen <= s_last;
            end
          end
        end

        WRITE: begin
          sum        <= sum + data_in;
          word_count <= word_count + WC_W'(1);
          if (last_seen) begin
            state <= VERIFY;
            a     <= '0;
            vk    <= '0;
            phase <= 1'b0;
            vsum  <= '0;
          end else begin
            state   <= FILL;
            s_ready <= 1'b1;
          end
        end

        VERIFY: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            vsum  <= vsum_next_c;
            phase <= 1'b0;
            if (vk == word_count - WC_W'(1)) begin
              state     <= verify_ok_c ? DONE : ERROR;
              busy      <= 1'b0;
              done      <= verify_ok_c;
              error     <= !verify_ok_c;
              cpu_rst_n <= verify_ok_c;
            end else begin
              vk <= vk + WC_W'(1);
              a  <= ADDR_WIDTH'({vk + WC_W'(1), 2'b00});
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader with a behavioural memory.
module tb_imem_loader;

  localparam int unsigned DIR_W = 10;
  localparam int unsigned MAXW  = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              s_last;
  logic [DIR_W-1:0]  dir;
  logic [31:0]       data_in;
  logic              we;
  logic [31:0]       a;
  logic [31:0]       rd;
  logic              busy;
  logic              done;
  logic              error;
  logic [DIR_W-2:0]  word_count;
  logic              cpu_rst_n;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [MAXW];
  logic        flip;
  logic [31:0] wr_dir_q[$];
  logic [31:0] wr_data_q[$];
  int          proto_viol = 0;
  logic        we_d = 1'b0;

  localparam logic [31:0] FIB [10] = '{
    32'h00000513, 32'h00100593, 32'h00a00613, 32'h00b506b3, 32'h00058513,
    32'h00068593, 32'hfff60613, 32'h00060463, 32'hfedff06f, 32'h0000006f
  };

  always #5 clk = ~clk;

  imem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .dir        (dir),
    .data_in    (data_in),
    .we         (we),
    .a          (a),
    .rd         (rd),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count),
    .cpu_rst_n  (cpu_rst_n)
  );

  // Combinational-read memory; optional bit-0 corruption at byte address 8.
  always_comb rd = mem[a[9:2]] ^ {31'b0, (flip && (a == 32'd8))};

  // Memory write port plus write log and protocol watch.
  always @(negedge clk) begin
    if (we) begin
      mem[dir[9:2]] <= data_in;
      wr_dir_q.push_back(32'(dir));
      wr_data_q.push_back(data_in);
      if (dir[1:0] != 2'b00 || we_d || !busy) proto_viol <= proto_viol + 1;
    end
    we_d <= we;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 0);
    chk({tag, "_we"}, 32'(we), 0);
    chk({tag, "_dir"}, 32'(dir), 0);
    chk({tag, "_data_in"}, data_in, 0);
    chk({tag, "_a"}, a, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_word_count"}, 32'(word_count), 0);
    chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Stream bytes with random idle gaps; s_last on the final byte if requested.
  task automatic send_bytes(input logic [7:0] img[$], input int gap_pct, input bit mark_last);
    for (int i = 0; i < img.size(); i++) begin
      int budget = 2000;
      while (int'($urandom_range(99)) < gap_pct) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = img[i];
      s_last  = mark_last && (i == img.size() - 1);
      while (!s_ready && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (budget == 0) begin
        chk("s_ready_timeout", 32'(s_ready), 1);
        break;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_end();
    int budget = 5000;
    while (!(done || error) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("end_timeout", 32'(budget == 0), 0);
  endtask

  // Reference: little-endian packing, zero pad, capacity limit, read-back verdict.
  task automatic check_load(input string tag, input logic [7:0] img[$], input int base,
                            input bit rb_ok);
    logic [31:0] words[$];
    int          nw;
    bit          ovf;
    bit          good;
    for (int i = 0; i < img.size(); i++) begin
      if (i % 4 == 0) words.push_back(32'h0);
      words[i/4] = words[i/4] | (32'(img[i]) << (8 * (i % 4)));
    end
    ovf  = img.size() > int'(MAXW * 4);
    nw   = ovf ? int'(MAXW) : words.size();
    good = !ovf && rb_ok;
    chk({tag, "_nwrites"}, 32'(wr_data_q.size() - base), 32'(nw));
    for (int i = 0; i < nw; i++) begin
      if (base + i < wr_data_q.size()) begin
        chk($sformatf("%s_dir%0d", tag, i), wr_dir_q[base+i], 32'(i * 4));
        chk($sformatf("%s_data%0d", tag, i), wr_data_q[base+i], words[i]);
      end
    end
    chk({tag, "_word_count"}, 32'(word_count), 32'(nw));
    chk({tag, "_done"}, 32'(done), 32'(good));
    chk({tag, "_error"}, 32'(error), 32'(!good));
    chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(good));
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_s_ready"}, 32'(s_ready), 0);
    chk({tag, "_protocol"}, 32'(proto_viol), 0);
  endtask

  task automatic run_load(input string tag, input logic [7:0] img[$], input int gap_pct,
                          input bit rb_ok);
    int base;
    base = wr_data_q.size();
    pulse_start();
    send_bytes(img, gap_pct, 1'b1);
    wait_end();
    check_load(tag, img, base, rb_ok);
  endtask

  initial begin
    logic [7:0]  fib[$];
    logic [7:0]  part[$];
    logic [7:0]  img[$];
    logic [7:0]  head[$];
    logic [31:0] w;
    int          len;

    for (int i = 0; i < int'(MAXW); i++) mem[i] = 32'h0;
    flip = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h0; s_last = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      w = FIB[i/4];
      fib.push_back(w[8*(i%4) +: 8]);
    end
    part = '{8'h13, 8'h05, 8'h00, 8'h00, 8'hAA, 8'hBB};

    run_load("fib", fib, 0, 1'b1);
    chk("fib_mem8", mem[8], 32'hFEDFF06F);

    run_load("partial", part, 0, 1'b1);

    run_load("fib_gaps", fib, 35, 1'b1);

    for (int t = 0; t < 6; t++) begin
      img.delete();
      len = int'($urandom_range(80, 1));
      for (int i = 0; i < len; i++) img.push_back(8'($urandom));
      run_load($sformatf("rand%0d", t), img, 30, 1'b1);
    end

    img.delete();
    for (int i = 0; i < int'(MAXW * 4 + 1); i++) img.push_back(8'($urandom));
    run_load("overflow", img, 0, 1'b1);

    flip = 1'b1;
    run_load("vfail", fib, 10, 1'b0);
    flip = 1'b0;
    run_load("reload", fib, 0, 1'b1);

    // Abandon a partial load mid-word, then reload from a clean state.
    head = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    pulse_start();
    send_bytes(head, 0, 1'b0);
    chk("midfill_word_count", 32'(word_count), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("midfill_reset");
    rst_n = 1'b1;
    run_load("after_reset", part, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
